clk_sel_ctrl: RTL and testbench

//  Request-side controller for the glitch-free clock switch: owns and drives its sel_clk1 input.

---
 rtl/clk_sw_pkg.sv | 21 ++
 rtl/clk_sel_cnt.sv | 29 ++
 rtl/clk_sel_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_sw_pkg.sv
// rtl/clk_sw_pkg.sv - shared state encoding, select constants and timing defaults for the clock switch
package clk_sw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_DWELL_CYC  = 32;
  localparam int DEF_CNT_W      = 8;

  function automatic bit fits_cnt(input int val, input int width);
    return (val >= 0) && (longint'(val) <= ((longint'(1) << width) - 1));
  endfunction

endpackage

// File: rtl/clk_sel_cnt.sv
// rtl/clk_sel_cnt.sv - loadable saturating down-counter with zero flag, shared by SETTLE and DWELL
module clk_sel_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - request-side select controller for the glitch-free clock switch
// Optional automatic failover on clock loss is enabled with CLK_FAILOVER_EN.
module clk_sel_ctrl
  import clk_sw_pkg::*;
#(
  parameter int   SETTLE_CYC     = DEF_SETTLE_CYC,
  parameter int   DWELL_CYC      = DEF_DWELL_CYC,
  parameter logic RESET_SEL_CLK1 = SEL_CLK1,
  parameter int   CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_sel_clk1,
  output logic req_ready,
  output logic sel_clk1,
  output logic busy,
  output logic done,
  input  logic fail_clk1,
  input  logic fail_clk2,
  output logic failover
);

  if ((SETTLE_CYC < 1) || !fits_cnt(SETTLE_CYC, CNT_W) || !fits_cnt(DWELL_CYC, CNT_W)) begin : g_bad_param
    $error("clk_sel_ctrl: SETTLE_CYC/DWELL_CYC out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETTLE_LD     = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD      = CNT_W'((DWELL_CYC > 0) ? (DWELL_CYC - 1) : 0);
  localparam logic             DONE_ON_ENTRY = (SETTLE_CYC == 1);
  localparam logic             HAS_DWELL     = (DWELL_CYC > 0);

  state_t           r_state;
  logic             r_sel;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_failover;

  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_fo_trig;
  logic             w_accept;
  logic             w_start_settle;
  logic             w_start_dwell;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_load_val;

`ifdef CLK_FAILOVER_EN
  logic w_act_fail;
  logic w_oth_fail;

  // Only a loss of the active clock with the other one healthy is worth switching for.
  assign w_act_fail = r_sel ? fail_clk1 : fail_clk2;
  assign w_oth_fail = r_sel ? fail_clk2 : fail_clk1;
  assign w_fo_trig  = ((r_state == IDLE) || (r_state == DWELL)) && w_act_fail && !w_oth_fail;
`else
  logic w_unused_fail;

  assign w_unused_fail = fail_clk1 | fail_clk2;
  assign w_fo_trig     = 1'b0;
`endif

  assign w_accept       = (r_state == IDLE) && req_valid && r_ready && !w_fo_trig;
  assign w_start_settle = w_fo_trig || (w_accept && (req_sel_clk1 != r_sel));
  assign w_start_dwell  = (r_state == SETTLE) && w_cnt_zero && HAS_DWELL;
  assign w_cnt_load     = w_start_settle || w_start_dwell;
  assign w_load_val     = w_start_settle ? SETTLE_LD : DWELL_LD;

  clk_sel_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_cnt_load),
    .i_load_val (w_load_val),
    .i_dec      (r_state != IDLE),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_sel      <= RESET_SEL_CLK1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_failover <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_settle) begin
        r_sel      <= ~r_sel;
        r_state    <= SETTLE;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
        r_done     <= DONE_ON_ENTRY;
        r_failover <= w_fo_trig;
      end else begin
        case (r_state)
          IDLE: begin
            r_ready <= 1'b1;
            if (w_accept) begin
              r_done     <= 1'b1;
              r_failover <= 1'b0;
            end
          end
          SETTLE: begin
            if (w_cnt_zero) begin
              if (HAS_DWELL) begin
                r_state <= DWELL;
              end else begin
                r_state <= IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              // Registered done must land in the cycle where the count reads zero.
              r_done <= (w_cnt == CNT_W'(1));
            end
          end
          DWELL: begin
            if (w_cnt_zero) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready = r_ready;
  assign sel_clk1  = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign failover  = r_failover;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - directed self-checking bench for clk_sel_ctrl (default timing 8/32)
module tb_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic req_valid;
  logic req_sel_clk1;
  logic req_ready;
  logic sel_clk1;
  logic busy;
  logic done;
  logic fail_clk1;
  logic fail_clk2;
  logic failover;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_sel_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_sel_clk1 (req_sel_clk1),
    .req_ready    (req_ready),
    .sel_clk1     (sel_clk1),
    .busy         (busy),
    .done         (done),
    .fail_clk1    (fail_clk1),
    .fail_clk2    (fail_clk2),
    .failover     (failover)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req_step(input logic s);
    req_valid    = 1'b1;
    req_sel_clk1 = s;
    step();
    req_valid    = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    check(tag, req_ready, 1);
  endtask

  initial begin
    int acc;
    rstn         = 1'b0;
    req_valid    = 1'b0;
    req_sel_clk1 = 1'b0;
    fail_clk1    = 1'b0;
    fail_clk2    = 1'b0;

    // 1: reset state, then first edge after release
    steps(3);
    check("rst_sel", sel_clk1, 1);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_failover", failover, 0);
    rstn = 1'b1;
    step();
    check("rel_ready", req_ready, 1);
    check("rel_sel", sel_clk1, 1);
    check("rel_busy", busy, 0);
    check("rel_done", done, 0);

    // 3: same selection -> done next cycle, no switch
    req_step(1'b1);
    check("same_done", done, 1);
    check("same_sel", sel_clk1, 1);
    check("same_ready", req_ready, 1);
    check("same_busy", busy, 0);
    step();
    check("same_done_clr", done, 0);

    // 2: switch to clk2 at T
    req_step(1'b0);
    check("sw_t1_sel", sel_clk1, 0);
    check("sw_t1_busy", busy, 1);
    check("sw_t1_ready", req_ready, 0);
    check("sw_t1_done", done, 0);
    steps(6);
    check("sw_t7_done", done, 0);
    step();
    check("sw_t8_done", done, 1);
    check("sw_t8_busy", busy, 1);
    step();
    check("sw_t9_done", done, 0);
    check("sw_t9_busy", busy, 1);
    steps(31);
    check("sw_t40_busy", busy, 1);
    check("sw_t40_ready", req_ready, 0);
    step();
    check("sw_t41_ready", req_ready, 1);
    check("sw_t41_busy", busy, 0);

    // 4: opposite request held through DWELL
    req_step(1'b1);
    check("hold_t1_sel", sel_clk1, 1);
    req_valid    = 1'b1;
    req_sel_clk1 = 1'b0;
    steps(20);
    check("hold_t21_sel", sel_clk1, 1);
    check("hold_t21_ready", req_ready, 0);
    steps(19);
    check("hold_t40_sel", sel_clk1, 1);
    check("hold_t40_ready", req_ready, 0);
    step();
    check("hold_t41_ready", req_ready, 1);
    check("hold_t41_sel", sel_clk1, 1);
    step();
    req_valid = 1'b0;
    check("hold_t42_sel", sel_clk1, 0);
    check("hold_t42_busy", busy, 1);
    steps(7);
    check("hold_t49_done", done, 1);
    wait_ready("hold_ready_timeout");

    // 5: reset mid-SETTLE aborts the switch
    req_step(1'b1);
    wait_ready("pre5_ready_timeout");
    check("pre5_sel", sel_clk1, 1);
    req_step(1'b0);
    check("r5_t1_sel", sel_clk1, 0);
    steps(3);
    rstn = 1'b0;
    #1;
    check("r5_sel", sel_clk1, 1);
    check("r5_busy", busy, 0);
    check("r5_ready", req_ready, 0);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      acc += done;
    end
    rstn = 1'b1;
    step();
    check("r5_rel_ready", req_ready, 1);
    for (int i = 0; i < 12; i++) begin
      acc += done;
      step();
    end
    check("r5_no_done", acc, 0);
    check("r5_idle_busy", busy, 0);

    // 6: clk1 loss while dwelling on clk1
    req_step(1'b0);
    wait_ready("pre6a_ready_timeout");
    req_step(1'b1);
    steps(11);
    check("fo_pre_busy", busy, 1);
    check("fo_pre_done", done, 0);
    fail_clk1 = 1'b1;
    fail_clk2 = 1'b0;
    step();
`ifdef CLK_FAILOVER_EN
    check("fo_sel", sel_clk1, 0);
    check("fo_flag", failover, 1);
    check("fo_busy", busy, 1);
    steps(6);
    check("fo_t7_done", done, 0);
    step();
    check("fo_t8_done", done, 1);
    fail_clk1 = 1'b0;
    wait_ready("fo_ready_timeout");
    check("fo_sticky", failover, 1);
    req_step(1'b0);
    check("fo_clr", failover, 0);
    check("fo_clr_done", done, 1);
    req_step(1'b1);
    steps(10);
    fail_clk1 = 1'b1;
    fail_clk2 = 1'b1;
    steps(3);
    check("fo_both_sel", sel_clk1, 1);
    check("fo_both_flag", failover, 0);
    fail_clk1 = 1'b0;
    fail_clk2 = 1'b0;
`else
    check("nofo_sel", sel_clk1, 1);
    check("nofo_flag", failover, 0);
    check("nofo_busy", busy, 1);
    fail_clk1 = 1'b0;
    wait_ready("nofo_ready_timeout");
    check("nofo_sel_end", sel_clk1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
